// File: rtl/uc_pkg.sv
// Shared definitions for the micro-coded sequencer: default sizes,
// opcode constants, FSM state encoding and small decode helpers.
package uc_pkg;

    localparam int DEF_PC_W        = 10;
    localparam int DEF_STACK_DEPTH = 4;
    localparam int DEF_ALU_W       = 3;

    localparam logic [5:0] OP_JMP  = 6'b010000;
    localparam logic [5:0] OP_JZ   = 6'b010001;
    localparam logic [5:0] OP_JNZ  = 6'b010010;
    localparam logic [5:0] OP_CALL = 6'b010011;
    localparam logic [5:0] OP_RET  = 6'b010100;
    // Any unassigned opcode behaves as NOP; this one is used as the IR reset value.
    localparam logic [5:0] OP_NOP  = 6'b011111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    function automatic logic is_li(input logic [5:0] op);
        return op[5];
    endfunction

    function automatic logic is_alu(input logic [5:0] op);
        return (op[5:3] == 3'b000);
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Push/pop are ignored when full/empty respectively;
// the sequencer checks full/empty itself and raises fault flags.
module ret_stack
    import uc_pkg::*;
#(
    parameter int W     = DEF_PC_W,
    parameter int DEPTH = DEF_STACK_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [W-1:0]     mem_r [DEPTH];
    logic [CNT_W-1:0] count_r;
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] rd_idx_s;

    assign wr_idx_s = count_r[IDX_W-1:0];
    assign rd_idx_s = IDX_W'(count_r - CNT_W'(1'b1));
    assign full     = (count_r == CNT_W'(DEPTH));
    assign empty    = (count_r == {CNT_W{1'b0}});
    assign top      = mem_r[rd_idx_s];

    // Occupancy counter; reset empties the stack and overrides push/pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (push && !full) begin
            count_r <= count_r + CNT_W'(1'b1);
        end else if (pop && !empty) begin
            count_r <= count_r - CNT_W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    // Entry storage; contents need no reset because the counter guards reads.
    always_ff @(posedge clk) begin
        if (reset && push && !full) begin
            mem_r[wr_idx_s] <= push_data;
        end
    end

endmodule

// File: rtl/uc_seq.sv
// Two-cycle micro-sequencer: FETCH latches an instruction, EXEC decodes it,
// drives datapath controls and computes the next PC. Stack faults park the
// sequencer in FAULT until reset.
module uc_seq
    import uc_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int ALU_W       = DEF_ALU_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic [PC_W-1:0]  target,
    input  logic             instr_valid,
    input  logic             zero,
    output logic             fetch_req,
    output logic [PC_W-1:0]  pc,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we,
    output logic             wez,
    output logic [ALU_W-1:0] AluOP,
    output logic             stack_ovf,
    output logic             stack_unf
);

    state_t            state_r, state_next_s;
    logic [PC_W-1:0]   pc_r, pc_next_s, pc_inc_s;
    logic [5:0]        ir_op_r;
    logic [PC_W-1:0]   ir_tgt_r;
    logic              ovf_r, unf_r;
    logic              ir_load_s, push_s, pop_s, set_ovf_s, set_unf_s;
    logic              s_inc_s, s_inm_s, we_s, wez_s;
    logic [ALU_W-1:0]  alu_op_s;
    logic [PC_W-1:0]   stk_top_s;
    logic              stk_full_s, stk_empty_s;

    // Wraps modulo 2^PC_W; also used as the pushed return address.
    assign pc_inc_s = pc_r + PC_W'(1'b1);

    ret_stack #(
        .W     (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .top       (stk_top_s),
        .full      (stk_full_s),
        .empty     (stk_empty_s)
    );

    // Next-state, next-PC, stack requests and EXEC-cycle control decode.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        ir_load_s    = 1'b0;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        set_ovf_s    = 1'b0;
        set_unf_s    = 1'b0;
        s_inc_s      = 1'b0;
        s_inm_s      = 1'b0;
        we_s         = 1'b0;
        wez_s        = 1'b0;
        alu_op_s     = {ALU_W{1'b0}};
        case (state_r)
            ST_FETCH: begin
                if (instr_valid) begin
                    ir_load_s    = 1'b1;
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                state_next_s = ST_FETCH;
                if (is_li(ir_op_r)) begin
                    s_inm_s   = 1'b1;
                    we_s      = 1'b1;
                    s_inc_s   = 1'b1;
                    pc_next_s = pc_inc_s;
                end else if (is_alu(ir_op_r)) begin
                    alu_op_s  = ALU_W'(ir_op_r[2:0]);
                    we_s      = 1'b1;
                    wez_s     = 1'b1;
                    s_inc_s   = 1'b1;
                    pc_next_s = pc_inc_s;
                end else begin
                    case (ir_op_r)
                        OP_JMP: begin
                            pc_next_s = ir_tgt_r;
                        end
                        OP_JZ, OP_JNZ: begin
                            if (zero == (ir_op_r == OP_JZ)) begin
                                pc_next_s = ir_tgt_r;
                            end else begin
                                s_inc_s   = 1'b1;
                                pc_next_s = pc_inc_s;
                            end
                        end
                        OP_CALL: begin
                            if (stk_full_s) begin
                                set_ovf_s    = 1'b1;
                                state_next_s = ST_FAULT;
                            end else begin
                                push_s    = 1'b1;
                                pc_next_s = ir_tgt_r;
                            end
                        end
                        OP_RET: begin
                            if (stk_empty_s) begin
                                set_unf_s    = 1'b1;
                                state_next_s = ST_FAULT;
                            end else begin
                                pop_s     = 1'b1;
                                pc_next_s = stk_top_s;
                            end
                        end
                        default: begin
                            s_inc_s   = 1'b1;
                            pc_next_s = pc_inc_s;
                        end
                    endcase
                end
            end
            ST_FAULT: begin
                state_next_s = ST_FAULT;
            end
            default: begin
                state_next_s = ST_FETCH;
            end
        endcase
    end

    // State, PC, IR and sticky fault registers; reset aborts any instruction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_FETCH;
            pc_r     <= {PC_W{1'b0}};
            ir_op_r  <= OP_NOP;
            ir_tgt_r <= {PC_W{1'b0}};
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            if (ir_load_s) begin
                ir_op_r  <= Opcode;
                ir_tgt_r <= target;
            end
            ovf_r <= ovf_r | set_ovf_s;
            unf_r <= unf_r | set_unf_s;
        end
    end

    // Controls are squelched combinationally while reset is asserted.
    assign fetch_req = reset & (state_r == ST_FETCH);
    assign s_inc     = reset & s_inc_s;
    assign s_inm     = reset & s_inm_s;
    assign we        = reset & we_s;
    assign wez       = reset & wez_s;
    assign AluOP     = reset ? alu_op_s : {ALU_W{1'b0}};
    assign pc        = pc_r;
    assign stack_ovf = ovf_r;
    assign stack_unf = unf_r;

endmodule

// File: doc/uc_seq.md
UC_SEQ -- requirements
Module: uc_seq

Interface
REQ-001 Parameter PC_W, default 10, program-counter and jump-target width.
REQ-002 Parameter STACK_DEPTH, default 4 (min 2), return-stack entries.
REQ-003 Parameter ALU_W, default 3, AluOP width.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 Opcode  in  6  opcode of the presented instruction.
REQ-007 target  in  PC_W  jump/call target field of the presented instruction.
REQ-008 instr_valid  in  1  Opcode/target valid this cycle.
REQ-009 zero  in  1  datapath zero flag.
REQ-010 fetch_req  out  1  sequencer ready to accept an instruction.
REQ-011 pc  out  PC_W  current program counter.
REQ-012 s_inc  out  1  1 = next PC is pc+1; 0 = loaded PC.
REQ-013 s_inm  out  1  register-file write data from immediate.
REQ-014 we  out  1  register-file write enable.
REQ-015 wez  out  1  zero-flag write enable.
REQ-016 AluOP  out  ALU_W  ALU operation.
REQ-017 stack_ovf, stack_unf  out  1 each  sticky stack fault flags.

Function
REQ-018 FSM states FETCH, EXEC, FAULT; fetch_req=1 only in FETCH.
REQ-019 FETCH: on instr_valid=1, latch Opcode/target into IR, go EXEC; else stay.
REQ-020 EXEC lasts exactly one cycle; control outputs valid only in EXEC, 0 in FETCH/FAULT.
REQ-021 Decode: Opcode[5]=1 -> LI: s_inm=1, we=1, wez=0, s_inc=1.
REQ-022 Opcode[5:3]=000 -> ALU: AluOP=Opcode[2:0] zero-extended/truncated to ALU_W, we=1, wez=1, s_inc=1.
REQ-023 010000 JMP: pc<=target, s_inc=0.
REQ-024 010001 JZ / 010010 JNZ: sampled zero in EXEC; taken -> pc<=target, s_inc=0; else pc+1, s_inc=1.
REQ-025 010011 CALL: push pc+1, pc<=target, s_inc=0.
REQ-026 010100 RET: pop into pc, s_inc=0.
REQ-027 All other opcodes NOP: pc+1, s_inc=1, no writes.
REQ-028 pc+1 wraps modulo 2^PC_W; pushed return address wraps identically.
REQ-029 PC updates on the EXEC->FETCH edge; instruction throughput 2 cycles minimum.
REQ-030 CALL with stack full: no push, pc unchanged, stack_ovf<=1, go FAULT.
REQ-031 RET with stack empty: pc unchanged, stack_unf<=1, go FAULT.
REQ-032 FAULT held until reset; fetch_req=0, pc frozen.
REQ-033 Push to the last free entry (count=STACK_DEPTH-1) is legal and fills the stack.

Reset
REQ-034 reset=0 at edge: pc=0, stack empty, IR=NOP, state FETCH, stack_ovf=stack_unf=0.
REQ-035 While reset=0 all control outputs and fetch_req forced 0 combinationally.
REQ-036 Reset in EXEC aborts instruction: no PC update, no stack change; reset dominates all.

Structure
REQ-037 Package uc_pkg holds opcode constants, state encoding, default parameter values.
REQ-038 Sub-module ret_stack: parametrised LIFO (PC_W x STACK_DEPTH) with push, pop, full, empty.

Verification
REQ-039 Reset then LI(100000), ADD(000010): EXEC cycles show s_inm=1/we=1/wez=0, then AluOP=010/we=1/wez=1; pc 0->1->2.
REQ-040 JZ target=15 at pc=2: zero=1 -> pc=15, s_inc=0; repeat with zero=0 -> pc=3, s_inc=1.
REQ-041 CALL 20 at pc=5, RET at pc=20: pc=20 then pc=6; stack empty afterwards.
REQ-042 Five nested CALLs, STACK_DEPTH=4: fifth sets stack_ovf=1, FAULT, pc frozen; RET on empty stack sets stack_unf=1.
REQ-043 instr_valid held 0 for 3 cycles: fetch_req stays 1, no outputs asserted, pc stable.
REQ-044 PC_W=4, pc=15, NOP -> pc=0; reset=0 during EXEC of JMP 7 -> pc=0, we=0.
